spi_cmd_decoder: RTL and testbench

- Sits directly downstream of spi_serdes.
- Consumes received bytes (rxShiftReg/dataReady) and frames them into register-access commands to the mixer's parameter memory: a command byte, a 16-bit address, then DATA_BYTES-wide data words with address auto-increment.
- For read commands it fetches memory words and feeds them back to the serdes via txData/load, MSB byte first.

---
 rtl/spi_cmd_pkg.sv | 20 ++
 rtl/spi_cmd_decoder_if.sv | 30 +++
 rtl/spi_ssel_sync.sv | 34 +++
 rtl/spi_cmd_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI register-access command decoder.
package spi_cmd_pkg;

   localparam int unsigned PACKET_WIDTH     = 8;
   localparam int unsigned CMD_WRITE_BIT    = 7;
   localparam int unsigned FRAME_ADDR_WIDTH = 16;

   localparam logic [PACKET_WIDTH-1:0] TX_IDLE_BYTE = 8'h00;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR_HI,
      ADDR_LO,
      FETCH,
      WDATA,
      RDATA
   } state_e;

endpackage : spi_cmd_pkg

// File: rtl/spi_cmd_decoder_if.sv
// Serdes byte stream plus parameter-memory port seen by the command decoder.
interface spi_cmd_decoder_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_BYTES = 3
);
   import spi_cmd_pkg::*;

   localparam int unsigned DATA_WIDTH = PACKET_WIDTH * DATA_BYTES;

   logic [PACKET_WIDTH-1:0] rxData;
   logic                    dataReady;
   logic [PACKET_WIDTH-1:0] txData;
   logic                    load;
   logic [ADDR_WIDTH-1:0]   memAddr;
   logic [DATA_WIDTH-1:0]   memWrData;
   logic                    memWrEn;
   logic                    memRdEn;
   logic [DATA_WIDTH-1:0]   memRdData;

   modport slave (
      input  rxData, dataReady, memRdData,
      output txData, load, memAddr, memWrData, memWrEn, memRdEn
   );

   modport master (
      output rxData, dataReady, memRdData,
      input  txData, load, memAddr, memWrData, memWrEn, memRdEn
   );

endinterface : spi_cmd_decoder_if

// File: rtl/spi_ssel_sync.sv
// Synchronises the raw active-low slave select into clk and flags its edges.
module spi_ssel_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ssel_n_async,
   output logic fall_c,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   // Reset to deselected so a held-low select after reset still needs a clean edge history.
   always_comb begin
      sync_d = SYNC_STAGES'({sync_q, ssel_n_async});
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign fall_c = prev_q & ~sync_q[SYNC_STAGES-1];
   assign rise_c = ~prev_q & sync_q[SYNC_STAGES-1];

endmodule : spi_ssel_sync

// File: rtl/spi_cmd_decoder.sv
// Frames serdes bytes into parameter-memory read/write bursts with address
// auto-increment and streams read words back to the serdes MSB byte first.
module spi_cmd_decoder
   import spi_cmd_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_BYTES  = 3,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               spi_SSEL,
   spi_cmd_decoder_if.slave   bus
);

   localparam int unsigned DATA_WIDTH = PACKET_WIDTH * DATA_BYTES;
   localparam int unsigned CNT_WIDTH  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(DATA_BYTES - 1);

   logic ssel_fall_c;
   logic ssel_rise_c;

   spi_ssel_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ssel_sync (
      .clk          (clk),
      .rst_n        (reset_n),
      .ssel_n_async (spi_SSEL),
      .fall_c       (ssel_fall_c),
      .rise_c       (ssel_rise_c)
   );

   state_e                  state_q, state_d;
   logic                    dir_q, dir_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [CNT_WIDTH-1:0]    byte_cnt_q, byte_cnt_d;
   logic [DATA_WIDTH-1:0]   wr_word_q, wr_word_d;
   logic [DATA_WIDTH-1:0]   tx_word_q, tx_word_d;
   logic                    load_q, load_d;
   logic [PACKET_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
   logic                    mem_wr_en_q, mem_wr_en_d;
   logic                    mem_rd_en_q, mem_rd_en_d;

   logic [FRAME_ADDR_WIDTH-1:0] frame_addr;
   logic [ADDR_WIDTH-1:0]       addr_inc;
   logic [ADDR_WIDTH-1:0]       addr_lo;
   logic [DATA_WIDTH-1:0]       wr_word_shift;
   logic [DATA_WIDTH-1:0]       tx_word_shift;

   // Address arithmetic truncates to ADDR_WIDTH, dropping unused frame address bits.
   always_comb begin
      frame_addr    = FRAME_ADDR_WIDTH'(addr_q);
      addr_inc      = addr_q + ADDR_WIDTH'(1);
      addr_lo       = ADDR_WIDTH'({frame_addr[15:8], bus.rxData});
      wr_word_shift = DATA_WIDTH'({wr_word_q, bus.rxData});
      tx_word_shift = DATA_WIDTH'({tx_word_q, TX_IDLE_BYTE});
   end

   always_comb begin
      state_d       = state_q;
      dir_d         = dir_q;
      addr_d        = addr_q;
      byte_cnt_d    = byte_cnt_q;
      wr_word_d     = wr_word_q;
      tx_word_d     = tx_word_q;
      load_d        = 1'b0;
      tx_data_d     = tx_data_q;
      mem_addr_d    = mem_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      mem_wr_en_d   = 1'b0;
      mem_rd_en_d   = 1'b0;

      if (ssel_rise_c) begin
         // Deselect wins over a coincident byte; any partial word is dropped.
         state_d    = IDLE;
         byte_cnt_d = '0;
         wr_word_d  = '0;
      end else if (ssel_fall_c) begin
         state_d    = CMD;
         byte_cnt_d = '0;
         load_d     = 1'b1;
         tx_data_d  = TX_IDLE_BYTE;
      end else begin
         unique case (state_q)
            IDLE: begin
            end
            CMD: begin
               if (bus.dataReady) begin
                  dir_d     = bus.rxData[CMD_WRITE_BIT];
                  state_d   = ADDR_HI;
                  load_d    = 1'b1;
                  tx_data_d = TX_IDLE_BYTE;
               end
            end
            ADDR_HI: begin
               if (bus.dataReady) begin
                  addr_d    = ADDR_WIDTH'({bus.rxData, frame_addr[7:0]});
                  state_d   = ADDR_LO;
                  load_d    = 1'b1;
                  tx_data_d = TX_IDLE_BYTE;
               end
            end
            ADDR_LO: begin
               if (bus.dataReady) begin
                  addr_d     = addr_lo;
                  byte_cnt_d = '0;
                  if (dir_q) begin
                     state_d   = WDATA;
                     wr_word_d = '0;
                     load_d    = 1'b1;
                     tx_data_d = TX_IDLE_BYTE;
                  end else begin
                     state_d     = FETCH;
                     mem_rd_en_d = 1'b1;
                     mem_addr_d  = addr_lo;
                  end
               end
            end
            FETCH: begin
               // First FETCH cycle has the read strobe out; data lands on the second.
               if (!mem_rd_en_q) begin
                  tx_word_d  = bus.memRdData;
                  tx_data_d  = bus.memRdData[DATA_WIDTH-1 -: PACKET_WIDTH];
                  load_d     = 1'b1;
                  byte_cnt_d = '0;
                  state_d    = RDATA;
               end
            end
            WDATA: begin
               if (bus.dataReady) begin
                  wr_word_d = wr_word_shift;
                  load_d    = 1'b1;
                  tx_data_d = TX_IDLE_BYTE;
                  if (byte_cnt_q == LAST_BYTE) begin
                     mem_wr_en_d   = 1'b1;
                     mem_addr_d    = addr_q;
                     mem_wr_data_d = wr_word_shift;
                     addr_d        = addr_inc;
                     byte_cnt_d    = '0;
                  end else begin
                     byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
                  end
               end
            end
            RDATA: begin
               if (bus.dataReady) begin
                  if (byte_cnt_q < LAST_BYTE) begin
                     byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
                     tx_word_d  = tx_word_shift;
                     tx_data_d  = tx_word_shift[DATA_WIDTH-1 -: PACKET_WIDTH];
                     load_d     = 1'b1;
                  end else begin
                     addr_d      = addr_inc;
                     byte_cnt_d  = '0;
                     state_d     = FETCH;
                     mem_rd_en_d = 1'b1;
                     mem_addr_d  = addr_inc;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         dir_q         <= 1'b0;
         addr_q        <= '0;
         byte_cnt_q    <= '0;
         wr_word_q     <= '0;
         tx_word_q     <= '0;
         load_q        <= 1'b0;
         tx_data_q     <= '0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
         mem_wr_en_q   <= 1'b0;
         mem_rd_en_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         dir_q         <= dir_d;
         addr_q        <= addr_d;
         byte_cnt_q    <= byte_cnt_d;
         wr_word_q     <= wr_word_d;
         tx_word_q     <= tx_word_d;
         load_q        <= load_d;
         tx_data_q     <= tx_data_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_rd_en_q   <= mem_rd_en_d;
      end
   end

   assign bus.load      = load_q;
   assign bus.txData    = tx_data_q;
   assign bus.memAddr   = mem_addr_q;
   assign bus.memWrData = mem_wr_data_q;
   assign bus.memWrEn   = mem_wr_en_q;
   assign bus.memRdEn   = mem_rd_en_q;

endmodule : spi_cmd_decoder

// File: tb/tb_spi_cmd_decoder.sv
// Byte-level bench for spi_cmd_decoder: drives frames, models serdes and memory,
// and compares loads, writes and read strobes against a frame-level reference.
module tb_spi_cmd_decoder;
   import spi_cmd_pkg::*;

   localparam int unsigned AW = 16;
   localparam int unsigned DB = 3;
   localparam int unsigned SS = 2;
   localparam int unsigned DW = PACKET_WIDTH * DB;

   logic clk      = 1'b0;
   logic reset_n  = 1'b0;
   logic spi_SSEL = 1'b1;

   spi_cmd_decoder_if #(.ADDR_WIDTH(AW), .DATA_BYTES(DB)) bus ();

   spi_cmd_decoder #(
      .ADDR_WIDTH  (AW),
      .DATA_BYTES  (DB),
      .SYNC_STAGES (SS)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .spi_SSEL (spi_SSEL),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] dut_mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   logic [7:0]       frame_q [$];
   logic [7:0]       got_ld [$];
   logic [7:0]       exp_ld [$];
   logic [AW+DW-1:0] got_wr [$];
   logic [AW+DW-1:0] exp_wr [$];
   logic [AW-1:0]    got_rd [$];
   logic [AW-1:0]    exp_rd [$];

   int checks   = 0;
   int errors   = 0;
   int overlaps = 0;

   // Memory slave: word valid only in the cycle after the strobe, noise otherwise.
   always @(posedge clk) begin
      if (bus.memRdEn) bus.memRdData <= dut_mem[bus.memAddr];
      else             bus.memRdData <= DW'($urandom);
      if (bus.memWrEn) dut_mem[bus.memAddr] <= bus.memWrData;
   end

   always @(negedge clk) begin
      if (bus.load)                   got_ld.push_back(bus.txData);
      if (bus.memWrEn)                got_wr.push_back({bus.memAddr, bus.memWrData});
      if (bus.memRdEn)                got_rd.push_back(bus.memAddr);
      if (bus.memWrEn && bus.memRdEn) overlaps++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [7:0] b);
      bus.rxData    = b;
      bus.dataReady = 1'b1;
      tick();
      bus.dataReady = 1'b0;
      bus.rxData    = 8'($urandom);
   endtask

   task automatic clear_got();
      got_ld.delete();
      got_wr.delete();
      got_rd.delete();
   endtask

   // Frame-level reference: n_acc accepted bytes of frame_q
   task automatic model_frame(input int n_acc);
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      int            j;
      exp_ld.delete();
      exp_wr.delete();
      exp_rd.delete();
      a = '0;
      if (n_acc >= 3) a = AW'({frame_q[1], frame_q[2]});
      exp_ld.push_back(8'h00);
      for (int i = 0; i < n_acc; i++) begin
         if (frame_q[0][7] || i < 2) begin
            exp_ld.push_back(8'h00);
         end else begin
            j = i - 2;
            w = ref_mem[AW'(a + AW'(j / DB))];
            exp_ld.push_back(8'(w >> (8 * (DB - 1 - (j % DB)))));
         end
      end
      if (n_acc >= 3 && frame_q[0][7]) begin
         for (int k = 0; k < (n_acc - 3) / DB; k++) begin
            w = '0;
            for (int b = 0; b < DB; b++) w = DW'({w, frame_q[3 + k * DB + b]});
            exp_wr.push_back({AW'(a + AW'(k)), w});
            ref_mem[AW'(a + AW'(k))] = w;
         end
      end
      if (n_acc >= 3 && !frame_q[0][7]) begin
         for (int k = 0; k <= (n_acc - 3) / DB; k++) exp_rd.push_back(AW'(a + AW'(k)));
      end
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_n_load"}, 64'(got_ld.size()), 64'(exp_ld.size()));
      for (int i = 0; i < got_ld.size() && i < exp_ld.size(); i++)
         check({tag, "_load_byte"}, 64'(got_ld[i]), 64'(exp_ld[i]));
      check({tag, "_n_write"}, 64'(got_wr.size()), 64'(exp_wr.size()));
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
         check({tag, "_write"}, 64'(got_wr[i]), 64'(exp_wr[i]));
      check({tag, "_n_read"}, 64'(got_rd.size()), 64'(exp_rd.size()));
      for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
         check({tag, "_read_addr"}, 64'(got_rd[i]), 64'(exp_rd[i]));
      check({tag, "_wr_rd_overlap"}, 64'(overlaps), 64'd0);
   endtask

   // drop_last: the final byte arrives in the same cycle the synced deselect is seen
   task automatic do_frame(input string tag, input bit drop_last);
      int n;
      n = frame_q.size();
      clear_got();
      spi_SSEL = 1'b0;
      repeat (6) tick();
      for (int i = 0; i < n; i++) begin
         if (drop_last && i == n - 1) begin
            spi_SSEL = 1'b1;
            repeat (SS) tick();
            pulse(frame_q[i]);
            repeat (6) tick();
         end else begin
            pulse(frame_q[i]);
            repeat ($urandom_range(4, 7)) tick();
         end
      end
      if (!drop_last) begin
         spi_SSEL = 1'b1;
         repeat (6) tick();
      end
      model_frame(drop_last ? n - 1 : n);
      check_frame(tag);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_load"},      64'(bus.load),      64'd0);
      check({tag, "_txData"},    64'(bus.txData),    64'd0);
      check({tag, "_memAddr"},   64'(bus.memAddr),   64'd0);
      check({tag, "_memWrData"}, 64'(bus.memWrData), 64'd0);
      check({tag, "_memWrEn"},   64'(bus.memWrEn),   64'd0);
      check({tag, "_memRdEn"},   64'(bus.memRdEn),   64'd0);
   endtask

   initial begin
      bit            dir;
      logic [AW-1:0] a;
      int            nd;
      bus.rxData    = 8'h00;
      bus.dataReady = 1'b0;
      for (int i = 0; i < (1 << AW); i++) begin
         dut_mem[i] = DW'($urandom);
         ref_mem[i] = dut_mem[i];
      end
      dut_mem[16'h0020] = 24'hABCDEF;  ref_mem[16'h0020] = 24'hABCDEF;
      dut_mem[16'h0021] = 24'h010203;  ref_mem[16'h0021] = 24'h010203;

      repeat (3) tick();
      check_outputs_zero("reset");
      reset_n = 1'b1;
      repeat (4) tick();

      clear_got();
      pulse(8'h80);
      repeat (5) tick();
      pulse(8'h12);
      repeat (5) tick();
      check("idle_loads",  64'(got_ld.size()), 64'd0);
      check("idle_writes", 64'(got_wr.size()), 64'd0);

      frame_q = '{8'h80, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56};
      do_frame("single_wr", 1'b0);
      check("single_wr_word", 64'(got_wr.size() > 0 ? got_wr[0] : '0), 64'h0010_123456);

      frame_q = '{8'h80, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      do_frame("burst_wr", 1'b0);

      frame_q = '{8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      do_frame("read", 1'b0);
      check("read_first_byte", 64'(got_ld.size() > 3 ? got_ld[3] : '0), 64'hAB);

      frame_q = '{8'h80, 8'h00, 8'h30, 8'hAA, 8'hBB};
      do_frame("abort", 1'b0);
      frame_q = '{8'h80, 8'h00, 8'h30, 8'hAA, 8'hBB, 8'hCC};
      do_frame("after_abort", 1'b0);

      frame_q = '{8'h80, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      do_frame("wrap", 1'b0);

      frame_q = '{8'h80, 8'h00, 8'h50, 8'h01, 8'h02, 8'h03};
      do_frame("ssel_wins", 1'b1);

      frame_q = '{8'h80, 8'h00, 8'h40, 8'hAA};
      clear_got();
      spi_SSEL = 1'b0;
      repeat (6) tick();
      for (int i = 0; i < 4; i++) begin
         pulse(frame_q[i]);
         repeat (5) tick();
      end
      reset_n = 1'b0;
      #1;
      check_outputs_zero("mid_reset");
      model_frame(4);
      check_frame("mid_reset");
      spi_SSEL = 1'b1;
      repeat (4) tick();
      reset_n = 1'b1;
      repeat (4) tick();
      frame_q = '{8'h80, 8'h00, 8'h40, 8'h01, 8'h02, 8'h03};
      do_frame("post_reset", 1'b0);

      for (int f = 0; f < 30; f++) begin
         dir = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       a = 16'hFFFE;
            1:       a = 16'hFFFF;
            default: a = 16'($urandom);
         endcase
         nd = $urandom_range(0, 8);
         frame_q.delete();
         frame_q.push_back({dir, 7'($urandom)});
         frame_q.push_back(a[15:8]);
         frame_q.push_back(a[7:0]);
         for (int i = 0; i < nd; i++) frame_q.push_back(8'($urandom));
         do_frame("random", ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_spi_cmd_decoder
